// File: rtl/bcd_7seg_scan_driver.sv
// Time-multiplexed BCD to 7-segment scan driver.
// A shadow register holds the digits and decimal points. A divider walks a
// one-hot anode across the digits. Each digit slot begins with one dark cycle
// so the anode never changes while segments are driven. Leading zeros can be
// suppressed, the whole display can be blanked, and codes 10-15 show a dash.
// All pin outputs are registered. Polarity inversion is the final stage.
module bcd_7seg_scan_driver #(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 1000,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit AN_ACTIVE_LOW  = 1'b0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          load,
    input  logic [4*NUM_DIGITS-1:0]       bcd_in,
    input  logic [NUM_DIGITS-1:0]         dp_in,
    input  logic                          lzs_en,
    input  logic                          blank,
    output logic [6:0]                    seg_o,
    output logic                          dp_o,
    output logic [NUM_DIGITS-1:0]         an_o,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
    output logic                          frame_done
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_ONE = NUM_DIGITS'(1);

    // Scan state
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  frame_done_q, frame_done_d;

    // Shadow copy of the displayed value
    logic [4*NUM_DIGITS-1:0] shadow_bcd_q;
    logic [NUM_DIGITS-1:0]   shadow_dp_q;

    // Output register, held active-high internally
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;

    // Per-digit views of the shadow
    logic [3:0]            digit_bcd [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] digit_zero;
    logic [NUM_DIGITS-1:0] lead_zero;
    logic [NUM_DIGITS-1:0] suppress;

    function automatic logic [6:0] decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h40;  // invalid BCD code shows a dash
        endcase
        return s;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign digit_bcd[gi]  = shadow_bcd_q[4*gi +: 4];
            assign digit_zero[gi] = (shadow_bcd_q[4*gi +: 4] == 4'd0);
        end
    endgenerate

    // Leading-zero run from the most significant digit downwards. Digit 0 always shows.
    always_comb begin
        logic zero_run;
        zero_run  = 1'b1;
        lead_zero = '0;
        suppress  = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_run     = zero_run & digit_zero[k];
            lead_zero[k] = zero_run;
            if (k != 0) begin
                suppress[k] = lzs_en & lead_zero[k];
            end
        end
    end

    // Refresh divider and digit counter. The frame pulse fires on the last digit's wrap.
    always_comb begin
        cnt_d        = cnt_q + CNT_W'(1);
        idx_d        = idx_q;
        frame_done_d = 1'b0;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (idx_q == IDX_LAST) begin
                idx_d        = '0;
                frame_done_d = 1'b1;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end
    end

    // Output select. The slot's first cycle (cnt 0) is dead time.
    always_comb begin
        seg_d = '0;
        dp_d  = 1'b0;
        an_d  = '0;
        if (!blank && (cnt_q != '0) && !suppress[idx_q]) begin
            seg_d = decode(digit_bcd[idx_q]);
            dp_d  = shadow_dp_q[idx_q];
            an_d  = AN_ONE << idx_q;
        end
    end

    // Scan counters and the frame pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Shadow capture. This never disturbs the scan position.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_bcd_q <= '0;
            shadow_dp_q  <= '0;
        end else if (load) begin
            shadow_bcd_q <= bcd_in;
            shadow_dp_q  <= dp_in;
        end
    end

    // Registered pin drive. Reset forces it dark.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg_q <= '0;
            dp_q  <= 1'b0;
            an_q  <= '0;
        end else begin
            seg_q <= seg_d;
            dp_q  <= dp_d;
            an_q  <= an_d;
        end
    end

    assign seg_o      = SEG_ACTIVE_LOW ? ~seg_q : seg_q;
    assign dp_o       = SEG_ACTIVE_LOW ? ~dp_q  : dp_q;
    assign an_o       = AN_ACTIVE_LOW  ? ~an_q  : an_q;
    assign digit_idx  = idx_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_bcd_7seg_scan_driver.sv
// Bench for bcd_7seg_scan_driver with 4 digits and 4 clocks per slot.
// It drives an active-high instance and an active-low instance with shared stimulus.
module tb_bcd_7seg_scan_driver;

    localparam int ND = 4;
    localparam int RD = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load = 1'b0;
    logic        lzs_en = 1'b0;
    logic        blank = 1'b0;
    logic [15:0] bcd_in = '0;
    logic [3:0]  dp_in = '0;

    logic [6:0]  seg_h, seg_l;
    logic        dp_h, dp_l;
    logic [3:0]  an_h, an_l;
    logic [1:0]  idx_h, idx_l;
    logic        fd_h, fd_l;

    always #5 clk = ~clk;

    bcd_7seg_scan_driver #(
        .NUM_DIGITS(ND), .REFRESH_DIV(RD), .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0)
    ) u_hi (
        .clk(clk), .reset(reset), .load(load), .bcd_in(bcd_in), .dp_in(dp_in),
        .lzs_en(lzs_en), .blank(blank), .seg_o(seg_h), .dp_o(dp_h), .an_o(an_h),
        .digit_idx(idx_h), .frame_done(fd_h)
    );

    bcd_7seg_scan_driver #(
        .NUM_DIGITS(ND), .REFRESH_DIV(RD), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
    ) u_lo (
        .clk(clk), .reset(reset), .load(load), .bcd_in(bcd_in), .dp_in(dp_in),
        .lzs_en(lzs_en), .blank(blank), .seg_o(seg_l), .dp_o(dp_l), .an_o(an_l),
        .digit_idx(idx_l), .frame_done(fd_l)
    );

    // One vector holds a loaded value, the lzs setting that goes with it, and
    // the expected glyph and lit mask for each digit.
    typedef struct packed {
        logic [15:0]     bcd;
        logic [3:0]      dp;
        logic            lzs;
        logic [3:0][6:0] seg;
        logic [3:0]      lit;
    } vec_t;

    typedef struct packed {
        logic [6:0] seg;
        logic       dp;
        logic [3:0] an;
        logic       fd;
        logic [1:0] idx;
    } exp_t;

    vec_t       vecs [9];
    vec_t       cur;
    exp_t       sb [$];
    logic [6:0] glyph [16];
    int         m_cnt = 0;
    int         m_idx = 0;
    int         n_cmp = 0;
    int         n_err = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s at t=%0t: got 0x%0h, expected 0x%0h", nm, $time, act, req);
        end
    endtask

    function automatic vec_t mk(input logic [15:0] b, input logic [3:0] d);
        vec_t v;
        v.bcd = b;
        v.dp  = d;
        v.lzs = 1'b0;
        v.lit = 4'hF;
        for (int k = 0; k < 4; k++) v.seg[k] = glyph[b[4*k +: 4]];
        return v;
    endfunction

    // Drive one clock. The expected result is pushed to the scoreboard from the
    // bench's own scan model. It is popped and compared after the edge.
    task automatic step(input logic ld, input vec_t nv, input logic bl);
        exp_t       e;
        exp_t       got;
        logic [6:0] nseg;
        logic       ndp;
        logic [3:0] nan;
        load   = ld;
        bcd_in = nv.bcd;
        dp_in  = nv.dp;
        blank  = bl;
        lzs_en = cur.lzs;
        e = '0;
        if (!bl && m_cnt != 0 && cur.lit[m_idx]) begin
            e.seg = cur.seg[m_idx];
            e.dp  = cur.dp[m_idx];
            e.an  = 4'b0001 << m_idx;
        end
        e.fd = (m_cnt == RD - 1) && (m_idx == ND - 1);
        if (m_cnt == RD - 1) begin
            m_cnt = 0;
            m_idx = (m_idx + 1) % ND;
        end else begin
            m_cnt++;
        end
        e.idx = 2'(m_idx);
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (ld) cur = nv;
        got  = sb.pop_front();
        nseg = ~got.seg;
        ndp  = ~got.dp;
        nan  = ~got.an;
        $display("t=%0t ld=%b bl=%b idx=%0d an=%b seg=%h dp=%b fd=%b",
                 $time, ld, bl, idx_h, an_h, seg_h, dp_h, fd_h);
        check("seg",     32'(seg_h), 32'(got.seg));
        check("dp",      32'(dp_h),  32'(got.dp));
        check("an",      32'(an_h),  32'(got.an));
        check("frame",   32'(fd_h),  32'(got.fd));
        check("idx",     32'(idx_h), 32'(got.idx));
        check("seg_n",   32'(seg_l), 32'(nseg));
        check("dp_n",    32'(dp_l),  32'(ndp));
        check("an_n",    32'(an_l),  32'(nan));
        check("frame_n", 32'(fd_l),  32'(got.fd));
        check("idx_n",   32'(idx_l), 32'(got.idx));
    endtask

    task automatic check_dark_reset(input string tag);
        check({tag, "_seg"},   32'(seg_h), 32'h00);
        check({tag, "_dp"},    32'(dp_h),  32'h0);
        check({tag, "_an"},    32'(an_h),  32'h0);
        check({tag, "_frame"}, 32'(fd_h),  32'h0);
        check({tag, "_idx"},   32'(idx_h), 32'h0);
        check({tag, "_seg_n"}, 32'(seg_l), 32'h7F);
        check({tag, "_dp_n"},  32'(dp_l),  32'h1);
        check({tag, "_an_n"},  32'(an_l),  32'hF);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        glyph = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                  7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

        vecs[0] = '{16'h0000, 4'b0000, 1'b0, {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 4'b1111};
        vecs[1] = '{16'h1234, 4'b0100, 1'b0, {7'h06, 7'h5B, 7'h4F, 7'h66}, 4'b1111};
        vecs[2] = '{16'h0050, 4'b0000, 1'b1, {7'h00, 7'h00, 7'h6D, 7'h3F}, 4'b0011};
        vecs[3] = '{16'h0000, 4'b0000, 1'b1, {7'h00, 7'h00, 7'h00, 7'h3F}, 4'b0001};
        vecs[4] = '{16'h00A0, 4'b0000, 1'b1, {7'h00, 7'h00, 7'h40, 7'h3F}, 4'b0011};
        vecs[5] = '{16'h9876, 4'b1001, 1'b1, {7'h6F, 7'h7F, 7'h07, 7'h7D}, 4'b1111};
        vecs[6] = '{16'hF0E5, 4'b0000, 1'b1, {7'h40, 7'h3F, 7'h40, 7'h6D}, 4'b1111};
        vecs[7] = '{16'h0007, 4'b1110, 1'b1, {7'h00, 7'h00, 7'h00, 7'h07}, 4'b0001};
        vecs[8] = '{16'h0000, 4'b1111, 1'b0, {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 4'b1111};

        // Reset state, then idle with an all-zero shadow
        cur = vecs[0];
        #12;
        check_dark_reset("rst");
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_cnt = 0;
        m_idx = 0;
        for (int c = 0; c < 2 * ND * RD; c++) step(1'b0, cur, 1'b0);

        // Table vectors. Lengths vary so loads land at different slot phases.
        for (int i = 0; i < 9; i++) begin
            step(1'b1, vecs[i], 1'b0);
            for (int c = 0; c < ND * RD + (i % 3); c++) step(1'b0, cur, 1'b0);
        end

        // Blank for 10 clocks mid-slot while the scan keeps running
        step(1'b1, vecs[1], 1'b0);
        step(1'b0, cur, 1'b0);
        for (int c = 0; c < 10; c++) step(1'b0, cur, 1'b1);
        for (int c = 0; c < 12; c++) step(1'b0, cur, 1'b0);

        // Load held high. The shadow follows the input on every edge.
        for (int c = 0; c < 10; c++) step(1'b1, mk(16'($urandom), 4'($urandom)), 1'b0);
        for (int c = 0; c < 6; c++) step(1'b0, cur, 1'b0);

        // Asynchronous reset mid-slot, then a clean restart from digit 0
        step(1'b1, vecs[5], 1'b0);
        step(1'b0, cur, 1'b0);
        step(1'b0, cur, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check_dark_reset("arst");
        @(posedge clk);
        #1;
        check_dark_reset("arst_hold");
        reset = 1'b0;
        load  = 1'b0;
        m_cnt = 0;
        m_idx = 0;
        cur   = vecs[0];
        for (int c = 0; c < 2 * ND * RD + 1; c++) step(1'b0, cur, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bcd_7seg_scan_driver.md
# bcd_7seg_scan_driver

Parametrised, time-multiplexed BCD-to-7-segment display driver. It captures a packed multi-digit BCD word and per-digit decimal points into a shadow register, then scans the digits one at a time onto a shared segment bus with one-hot anode select. It adds leading-zero suppression, global blanking, an invalid-code glyph, anode dead time and a frame-done pulse. It sits between the datapath's BCD outputs and the board display pins, succeeding the single-digit combinational decoder.

## Interface
- NUM_DIGITS, 4: digits scanned (≥2).
- REFRESH_DIV, 1000: clocks per digit slot (≥2).
- SEG_ACTIVE_LOW, 0: 1 inverts seg_o and dp_o at the pins.
- AN_ACTIVE_LOW, 0: 1 inverts an_o at the pins.

- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- load  in  1  capture bcd_in/dp_in into shadow on this edge.
- bcd_in  in  4*NUM_DIGITS  packed digits; [3:0] = digit 0 (least significant, rightmost).
- dp_in  in  NUM_DIGITS  decimal point per digit.
- lzs_en  in  1  leading-zero suppression enable (live, not shadowed).
- blank  in  1  force display dark (live).
- seg_o  out  7  segments; bit0=a … bit6=g; registered.
- dp_o  out  1  decimal point; registered.
- an_o  out  NUM_DIGITS  one-hot anode select; registered.
- digit_idx  out  clog2(NUM_DIGITS)  digit currently being scanned (internal counter).
- frame_done  out  1  one-cycle pulse when a full scan completes.

## Operation
- Shadow: on load=1, shadow_bcd<=bcd_in, shadow_dp<=dp_in. Scan is never restarted by load.
- Decode (active-high before polarity): 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F; codes 10–15 display dash 0x40.
- Scan: divider cnt counts 0..REFRESH_DIV-1. At cnt=REFRESH_DIV-1, cnt<=0 and digit_idx<=digit_idx+1, wrapping NUM_DIGITS-1→0. frame_done<=1 on the wrap edge only.
- LZS: when lzs_en=1, digit k is suppressed iff shadow digits NUM_DIGITS-1 down to k are all 0 and k≠0. Digit 0 is never suppressed. A nonzero invalid code (10–15) stops suppression.
- Output register, sampled every edge from pre-edge state (digit_idx, cnt, shadow, blank, lzs_en):
  - dark if blank=1, or the slot's digit is suppressed, or cnt=0 (dead cycle). Dark means an_o all inactive, seg_o=0, dp_o=0.
  - otherwise an_o=one-hot(digit_idx), seg_o=decode(digit), dp_o=shadow_dp[digit_idx].
  - Polarity inversion is applied after this logic.
- Reset (asynchronous): cnt=0, digit_idx=0, shadow=0, frame_done=0. Outputs are at their inactive levels: seg_o=0/dp_o=0 (all 1s if SEG_ACTIVE_LOW), an_o=0 (all 1s if AN_ACTIVE_LOW).

## Timing
- Output latency: 1 clock after the state it reflects. A new shadow value first appears on seg_o 2 edges after the load edge, if that digit is then lit.
- Each digit slot lasts REFRESH_DIV clocks, of which REFRESH_DIV-1 are lit. A frame lasts NUM_DIGITS*REFRESH_DIV clocks.
- blank and lzs_en take effect on the next edge (1 cycle), with no glitch on other digits.
- load and slot change on the same edge: the new slot shows the new value from its first lit cycle.
- load held high: shadow tracks the input every cycle.
- Reset mid-scan: immediate dark outputs. After release, digit 0 starts at cnt=0. The first frame_done occurs NUM_DIGITS*REFRESH_DIV edges after release.

## Test plan
(NUM_DIGITS=4, REFRESH_DIV=4, active-high unless stated)
- Reset then idle, no load → every lit cycle shows seg_o=0x3F. Digits 3–1 show 0x3F only with lzs_en=0. frame_done pulses every 16 clocks. an_o steps 0001→0010→0100→1000 with 1 dark cycle per slot.
- Load bcd_in=16'h1234, dp_in=4'b0100 → digit0 lit with 0x66, digit1 0x4F, digit2 0x5B with dp_o=1, digit3 0x06.
- Load 16'h0050, lzs_en=1 → digits 3 and 2 dark (an_o=0). Digit1 shows 0x6D. Digit0 shows 0x3F. Load 16'h0000 → only digit0 lit, showing 0x3F.
- Load 16'h00A0, lzs_en=1 → digit1 shows dash 0x40. Digit0 shows 0x3F. Digits 3 and 2 dark.
- Assert blank for 10 clocks mid-slot → outputs dark from the next edge. Scan counters keep advancing. Resume at the correct digit_idx.
- SEG_ACTIVE_LOW=1, AN_ACTIVE_LOW=1, assert reset mid-slot → seg_o=7'h7F, dp_o=1, an_o=4'hF immediately (asynchronous). After release, digit 0 resumes.
